// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB + 2-bit BHT branch predictor.
package branch_predictor_pkg;

  localparam int BHT_IDX_W_DEF = 6;
  localparam int BTB_IDX_W_DEF = 5;
  localparam int TAG_W         = 32;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic             valid;
    logic             is_cond;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  // Tag is the PC with the index and byte-offset bits shifted out, zero-extended.
  function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 32'sd2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function used to train the BHT.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Saturating increment on taken, decrement on not-taken.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
      else           ctr_next = ST;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
      else            ctr_next = SNT;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF-side BTB/BHT lookup, EX-side mispredict and training.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = BHT_IDX_W_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_IF,
  output logic        pred_taken_IF,
  output logic [31:0] pred_target_IF,
  output logic        init_busy,
  input  logic        inst_valid_EX,
  input  logic        br_valid_EX,
  input  logic        is_cond_EX,
  input  logic [31:0] pc_EX,
  input  logic        taken_EX,
  input  logic [31:0] target_EX,
  input  logic        pred_taken_EX,
  input  logic [31:0] pred_target_EX,
  output logic        mispredict_EX,
  output logic [31:0] redirect_pc_EX
);

  localparam int CLR_W = (BHT_IDX_W > BTB_IDX_W) ? BHT_IDX_W : BTB_IDX_W;
  localparam logic [CLR_W-1:0] CLR_LAST = {CLR_W{1'b1}};

  bp_state_e        state_q, state_d;
  logic [CLR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [1:0]  bht_q [2**BHT_IDX_W];
  btb_entry_t  btb_q [2**BTB_IDX_W];

  logic                 bht_we;
  logic [BHT_IDX_W-1:0] bht_widx;
  logic [1:0]           bht_wdata;
  logic                 btb_we;
  logic [BTB_IDX_W-1:0] btb_widx;
  btb_entry_t           btb_wdata;

  logic [BHT_IDX_W-1:0] if_bht_idx, ex_bht_idx;
  logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
  btb_entry_t           if_entry;
  logic                 if_hit;
  logic [1:0]           ex_ctr, ex_ctr_next;
  logic                 alias_s;

  assign if_btb_idx = pc_IF[BTB_IDX_W+1:2];
  assign ex_btb_idx = pc_EX[BTB_IDX_W+1:2];

`ifdef GSHARE_EN
  logic [5:0] ghr_q, ghr_d;
  assign if_bht_idx = pc_IF[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
  assign ex_bht_idx = pc_EX[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
`else
  assign if_bht_idx = pc_IF[BHT_IDX_W+1:2];
  assign ex_bht_idx = pc_EX[BHT_IDX_W+1:2];
`endif

  assign init_busy = (state_q == INIT);
  assign ex_ctr    = bht_q[ex_bht_idx];
  assign alias_s   = inst_valid_EX && !br_valid_EX && pred_taken_EX;

  sat_counter2 u_sat_counter2 (
    .ctr      (ex_ctr),
    .taken    (taken_EX),
    .ctr_next (ex_ctr_next)
  );

  // IF lookup; the tables are read before any same-cycle training write lands.
  always_comb begin
    if_entry       = btb_q[if_btb_idx];
    if_hit         = if_entry.valid && (if_entry.tag == btb_tag(pc_IF, BTB_IDX_W));
    pred_taken_IF  = 1'b0;
    pred_target_IF = pc_IF + 32'd4;
    if (state_q == RUN) begin
      pred_taken_IF = if_hit && (!if_entry.is_cond || bht_q[if_bht_idx][1]);
    end else begin
      pred_taken_IF = 1'b0;
    end
    if (pred_taken_IF) pred_target_IF = if_entry.target;
    else               pred_target_IF = pc_IF + 32'd4;
  end

  // EX mispredict detection, independent of the INIT/RUN state.
  always_comb begin
    mispredict_EX  = 1'b0;
    redirect_pc_EX = 32'd0;
    if (!inst_valid_EX) begin
      mispredict_EX  = 1'b0;
      redirect_pc_EX = 32'd0;
    end else if (br_valid_EX) begin
      mispredict_EX  = (taken_EX != pred_taken_EX) ||
                       (taken_EX && (target_EX != pred_target_EX));
      redirect_pc_EX = taken_EX ? target_EX : (pc_EX + 32'd4);
    end else begin
      mispredict_EX  = pred_taken_EX;
      redirect_pc_EX = pc_EX + 32'd4;
    end
  end

  // Next state, clear sweep and table write-port selection.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    bht_we    = 1'b0;
    bht_widx  = ex_bht_idx;
    bht_wdata = ex_ctr_next;
    btb_we    = 1'b0;
    btb_widx  = ex_btb_idx;
    btb_wdata = '0;
`ifdef GSHARE_EN
    ghr_d     = ghr_q;
`endif
    case (state_q)
      INIT: begin
        bht_we    = 1'b1;
        bht_widx  = clr_ptr_q[BHT_IDX_W-1:0];
        bht_wdata = WNT;
        btb_we    = 1'b1;
        btb_widx  = clr_ptr_q[BTB_IDX_W-1:0];
        btb_wdata = '0;
        clr_ptr_d = clr_ptr_q + CLR_W'(1'b1);
        if (clr_ptr_q == CLR_LAST) state_d = RUN;
        else                       state_d = INIT;
      end
      RUN: begin
        if (inst_valid_EX && br_valid_EX) begin
          if (is_cond_EX) begin
            bht_we = 1'b1;
`ifdef GSHARE_EN
            ghr_d  = {ghr_q[4:0], taken_EX};
`endif
          end else begin
            bht_we = 1'b0;
          end
          if (taken_EX) begin
            btb_we    = 1'b1;
            btb_wdata = '{valid: 1'b1, is_cond: is_cond_EX,
                          tag: btb_tag(pc_EX, BTB_IDX_W), target: target_EX};
          end else begin
            btb_we = 1'b0;
          end
        end else if (alias_s) begin
          btb_we    = 1'b1;
          btb_wdata = '0;
        end else begin
          btb_we = 1'b0;
        end
      end
      default: begin
        state_d   = INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
`ifdef GSHARE_EN
      ghr_q     <= 6'd0;
`endif
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
`ifdef GSHARE_EN
      ghr_q     <= ghr_d;
`endif
    end
  end

  // Table storage; contents are cleared by the INIT sweep rather than by rst.
  always_ff @(posedge clk) begin
    if (!rst && bht_we) bht_q[bht_widx] <= bht_wdata;
    if (!rst && btb_we) btb_q[btb_widx] <= btb_wdata;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_IF = 32'd0;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic        init_busy;
  logic        inst_valid_EX = 1'b0, br_valid_EX = 1'b0, is_cond_EX = 1'b0;
  logic [31:0] pc_EX = 32'd0, target_EX = 32'd0, pred_target_EX = 32'd0;
  logic        taken_EX = 1'b0, pred_taken_EX = 1'b0;
  logic        mispredict_EX;
  logic [31:0] redirect_pc_EX;

  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF),
    .pred_target_IF(pred_target_IF), .init_busy(init_busy),
    .inst_valid_EX(inst_valid_EX), .br_valid_EX(br_valid_EX), .is_cond_EX(is_cond_EX),
    .pc_EX(pc_EX), .taken_EX(taken_EX), .target_EX(target_EX),
    .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
    .mispredict_EX(mispredict_EX), .redirect_pc_EX(redirect_pc_EX)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: counters 0..3, BTB entries remember the full branch PC.
  int          ctr_m [64];
  bit          v_m   [32];
  bit          c_m   [32];
  logic [31:0] pcm_m [32];
  logic [31:0] tg_m  [32];
  int          ghr_m;
  bit          running;

  logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h280, 32'h300,
                            32'h1100, 32'hFFFF_FFFC, 32'h7C, 32'h84};

  function automatic int bidx(logic [31:0] pc);
    int i;
    i = int'((pc / 32'd4) % 32'd64);
`ifdef GSHARE_EN
    i = i ^ ghr_m;
`endif
    return i;
  endfunction

  function automatic int tidx(logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd32);
  endfunction

  function automatic bit m_pt(logic [31:0] pc);
    int j;
    j = tidx(pc);
    if (!running) return 1'b0;
    if (!(v_m[j] && (pcm_m[j] / 32'd128) == (pc / 32'd128))) return 1'b0;
    return !c_m[j] || (ctr_m[bidx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(logic [31:0] pc);
    return m_pt(pc) ? tg_m[tidx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!inst_valid_EX) return 1'b0;
    if (br_valid_EX) return (taken_EX != pred_taken_EX) || (taken_EX && target_EX != pred_target_EX);
    return pred_taken_EX;
  endfunction

  function automatic logic [31:0] m_redir();
    if (!inst_valid_EX) return 32'd0;
    if (br_valid_EX && taken_EX) return target_EX;
    return pc_EX + 32'd4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ctr_m[i] = 1;
    for (int i = 0; i < 32; i++) v_m[i] = 1'b0;
    ghr_m   = 0;
    running = 1'b0;
  endtask

  task automatic model_update();
    int i, j;
    if (!running) return;
    j = tidx(pc_EX);
    if (inst_valid_EX && br_valid_EX) begin
      if (is_cond_EX) begin
        i = bidx(pc_EX);
        if (taken_EX) ctr_m[i] = (ctr_m[i] == 3) ? 3 : ctr_m[i] + 1;
        else          ctr_m[i] = (ctr_m[i] == 0) ? 0 : ctr_m[i] - 1;
        ghr_m = ((ghr_m * 2) + (taken_EX ? 1 : 0)) % 64;
      end
      if (taken_EX) begin
        v_m[j] = 1'b1; c_m[j] = is_cond_EX; pcm_m[j] = pc_EX; tg_m[j] = target_EX;
      end
    end else if (inst_valid_EX && pred_taken_EX) begin
      v_m[j] = 1'b0;
    end
  endtask

  task automatic set_ex(bit iv, bit bv, bit c, logic [31:0] pc, bit t, logic [31:0] tg,
                        bit pt, logic [31:0] ptg);
    inst_valid_EX = iv; br_valid_EX = bv; is_cond_EX = c; pc_EX = pc;
    taken_EX = t; target_EX = tg; pred_taken_EX = pt; pred_target_EX = ptg;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  // Train a branch with the prediction the IF stage would have carried.
  task automatic train(bit c, logic [31:0] pc, bit t, logic [31:0] tg);
    set_ex(1'b1, 1'b1, c, pc, t, tg, m_pt(pc), m_ptg(pc));
  endtask

  // Wait out the clear sweep while hammering training and checking outputs.
  task automatic wait_init(string tag);
    int cnt;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 100) begin
      pc_IF = $urandom & 32'hFFFF_FFFC;
      set_ex(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      checks++;
      if (pred_taken_IF !== 1'b0 || pred_target_IF !== pc_IF + 32'd4) begin
        errors++;
        $display("FAIL %s_init_lookup: got %b/%h want 0/%h", tag, pred_taken_IF, pred_target_IF, pc_IF + 32'd4);
      end
      checks++;
      if (mispredict_EX !== m_mis() || redirect_pc_EX !== m_redir()) begin
        errors++;
        $display("FAIL %s_init_mispredict: got %b/%h want %b/%h", tag, mispredict_EX, redirect_pc_EX, m_mis(), m_redir());
      end
      cnt++;
      tick();
    end
    idle();
    running = 1'b1;
    checks++;
    if (cnt != 64) begin
      errors++;
      $display("FAIL %s_init_busy_cycles: got %0d want 64", tag, cnt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; idle(); model_clear();
    tick();
    rst = 1'b0;
    wait_init("reset");
    pc_IF = 32'h100;
    #1;
    checks++;
    if (pred_taken_IF !== 1'b0 || pred_target_IF !== 32'h104) begin
      errors++;
      $display("FAIL reset_untouched: got %b/%h want 0/00000104", pred_taken_IF, pred_target_IF);
    end
  endtask

  task automatic test_cond_train();
    pc_IF = 32'h100;
    train(1'b1, 32'h100, 1'b1, 32'h80);
    #1;
    checks++;
    if (mispredict_EX !== m_mis() || redirect_pc_EX !== m_redir()) begin
      errors++;
      $display("FAIL cond_first_mispredict: got %b/%h want %b/%h", mispredict_EX, redirect_pc_EX, m_mis(), m_redir());
    end
    checks++;
    if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
      errors++;
      $display("FAIL cond_same_cycle_lookup: got %b/%h want %b/%h", pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
    end
    tick(); idle();
    #1;
    checks++;
    if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
      errors++;
      $display("FAIL cond_after_train: got %b/%h want %b/%h", pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
    end
  endtask

  task automatic test_saturate();
    repeat (3) begin
      train(1'b1, 32'h100, 1'b1, 32'h80);
      tick();
    end
    train(1'b1, 32'h100, 1'b0, 32'h80);
    #1;
    checks++;
    if (mispredict_EX !== m_mis() || redirect_pc_EX !== m_redir()) begin
      errors++;
      $display("FAIL sat_not_taken: got %b/%h want %b/%h", mispredict_EX, redirect_pc_EX, m_mis(), m_redir());
    end
    tick(); idle();
    pc_IF = 32'h100;
    #1;
    checks++;
    if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
      errors++;
      $display("FAIL sat_still_taken: got %b/%h want %b/%h", pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
    end
  endtask

  task automatic test_jal_conflict();
    logic [31:0] pcs [3] = '{32'h200, 32'h280, 32'h200};
    logic [31:0] tgs [3] = '{32'h400, 32'h500, 32'h0};
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        train(1'b0, pcs[k], 1'b1, tgs[k]);
        tick(); idle();
      end
      for (int q = 0; q < 2; q++) begin
        pc_IF = (q == 0) ? 32'h200 : 32'h280;
        #1;
        checks++;
        if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
          errors++;
          $display("FAIL jal_lookup_%0d_%h: got %b/%h want %b/%h", k, pc_IF, pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
        end
      end
    end
  endtask

  task automatic test_alias();
    set_ex(1'b1, 1'b0, 1'b0, 32'h280, 1'b0, 32'd0, 1'b1, m_ptg(32'h280));
    #1;
    checks++;
    if (mispredict_EX !== m_mis() || redirect_pc_EX !== m_redir()) begin
      errors++;
      $display("FAIL alias_mispredict: got %b/%h want %b/%h", mispredict_EX, redirect_pc_EX, m_mis(), m_redir());
    end
    tick(); idle();
    pc_IF = 32'h280;
    #1;
    checks++;
    if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
      errors++;
      $display("FAIL alias_invalidated: got %b/%h want %b/%h", pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
    end
  endtask

  task automatic test_bubble();
    set_ex(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, $urandom, 1'b1, $urandom);
    #1;
    checks++;
    if (mispredict_EX !== 1'b0 || redirect_pc_EX !== 32'd0) begin
      errors++;
      $display("FAIL bubble_gated: got %b/%h want 0/00000000", mispredict_EX, redirect_pc_EX);
    end
    tick(); idle();
    pc_IF = 32'h100;
    #1;
    checks++;
    if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
      errors++;
      $display("FAIL bubble_no_train: got %b/%h want %b/%h", pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] tg;
    for (int n = 0; n < 400; n++) begin
      pc    = pool[$urandom_range(0, 7)];
      tg    = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : ($urandom & 32'hFFFF_FFFC);
      pc_IF = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) != 0)
        set_ex($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
               pc, $urandom_range(0, 1) == 1, tg, m_pt(pc), m_ptg(pc));
      else
        set_ex($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               pc, $urandom_range(0, 1) == 1, tg, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
      #1;
      checks++;
      if (pred_taken_IF !== m_pt(pc_IF) || pred_target_IF !== m_ptg(pc_IF)) begin
        errors++;
        $display("FAIL rand_lookup_%0d: pc %h got %b/%h want %b/%h", n, pc_IF, pred_taken_IF, pred_target_IF, m_pt(pc_IF), m_ptg(pc_IF));
      end
      checks++;
      if (mispredict_EX !== m_mis() || redirect_pc_EX !== m_redir()) begin
        errors++;
        $display("FAIL rand_mispredict_%0d: got %b/%h want %b/%h", n, mispredict_EX, redirect_pc_EX, m_mis(), m_redir());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 3; k++) begin
      train(1'b1, 32'h100, 1'b1, 32'h80); tick();
      train(1'b0, 32'h200, 1'b1, 32'h400); tick();
    end
    train(1'b1, 32'h300, 1'b1, 32'h40);
    rst = 1'b1; model_clear();
    tick();
    rst = 1'b0;
    wait_init("midreset");
    for (int k = 0; k < 8; k++) begin
      pc_IF = pool[k];
      #1;
      checks++;
      if (pred_taken_IF !== 1'b0 || pred_target_IF !== m_ptg(pc_IF)) begin
        errors++;
        $display("FAIL midreset_cleared_%h: got %b/%h want 0/%h", pc_IF, pred_taken_IF, pred_target_IF, m_ptg(pc_IF));
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cond_train();
    test_saturate();
    test_jal_conflict();
    test_alias();
    test_bubble();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
